// File: rtl/data_store_buffer.sv
// Posted-write buffer between the core data port and a multi-cycle memory bus.
// Stores queue in a small FIFO and retire in the background; loads take the port first.
module data_store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] core_address,
  input  logic [31:0] core_write_data,
  input  logic [3:0]  core_byte_enable,
  input  logic        core_read_enable,
  input  logic        core_write_enable,
  output logic [31:0] core_read_data,
  output logic        core_stall,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_byte_enable,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ready,
  output logic        buffer_empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [29:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [3:0]    r_be   [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_load;
  logic w_hazard;
  logic w_load_go;
  logic w_retire;
  logic w_push;
  logic w_pop;

  // A simultaneous read and write request is handled as a load.
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_load    = core_read_enable;
  assign w_load_go = w_load && !w_hazard;
  assign w_retire  = !w_load_go && (r_count != '0);
  assign w_pop     = w_retire && mem_ready;
  assign w_push    = core_write_enable && !core_read_enable && !w_full;

  // Word-address match against every live entry, byte enables ignored.
  always_comb begin
    w_hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(PW'(PW'(i) - r_head)) < r_count) && (r_addr[i] == core_address[31:2]))
        w_hazard = 1'b1;
    end
  end

  always_comb begin
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_byte_enable  = '0;
    core_read_data   = '0;
    if (w_load_go) begin
      mem_read_enable = 1'b1;
      mem_address     = core_address;
      mem_byte_enable = core_byte_enable;
      core_read_data  = mem_read_data;
    end else if (w_retire) begin
      mem_write_enable = 1'b1;
      mem_address      = {r_addr[r_head], 2'b00};
      mem_write_data   = r_data[r_head];
      mem_byte_enable  = r_be[r_head];
    end
    core_stall   = w_load ? (w_hazard || !mem_ready) : (core_write_enable && w_full);
    buffer_empty = (r_count == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload needs no reset; validity comes from the pointers and count.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_addr[r_tail] <= core_address[31:2];
      r_data[r_tail] <= core_write_data;
      r_be[r_tail]   <= core_byte_enable;
    end
  end

endmodule

// File: tb/tb_data_store_buffer.sv
// Self-checking bench for data_store_buffer: a queue scoreboard models the FIFO and
// checks the memory port every cycle, plus directed checks of the stall timing.
module tb_data_store_buffer;
  localparam int unsigned DEPTH = 4;

  logic        clock;
  logic        reset;
  logic [31:0] core_address;
  logic [31:0] core_write_data;
  logic [3:0]  core_byte_enable;
  logic        core_read_enable;
  logic        core_write_enable;
  logic [31:0] core_read_data;
  logic        core_stall;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic        buffer_empty;

  data_store_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .core_address(core_address), .core_write_data(core_write_data),
    .core_byte_enable(core_byte_enable), .core_read_enable(core_read_enable),
    .core_write_enable(core_write_enable), .core_read_data(core_read_data),
    .core_stall(core_stall), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_byte_enable(mem_byte_enable),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .buffer_empty(buffer_empty)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  int   n_vec    = 0;
  int   n_err    = 0;
  int   n_writes = 0;
  bit   hz, ld, go, full;
  ent_t e;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare the port against the queue model, then apply this edge's pop/push.
  always @(negedge clock) begin
    assert (!(core_read_enable && core_write_enable))
      else $error("illegal: read and write enable both set");
    if (reset) begin
      q.delete();
      check("rst_we", mem_write_enable, 1'b0);
      check("rst_re", mem_read_enable, 1'b0);
      check("rst_addr", mem_address, 32'h0);
      check("rst_empty", buffer_empty, 1'b1);
      check("rst_stall", core_stall, 1'b0);
    end else begin
      hz = 1'b0;
      foreach (q[i]) if (q[i].addr[31:2] == core_address[31:2]) hz = 1'b1;
      ld   = core_read_enable;
      go   = ld && !hz;
      full = (q.size() == DEPTH);
      check("empty", buffer_empty, q.size() == 0);
      check("stall", core_stall, ld ? (hz || !mem_ready) : (core_write_enable && full));
      if (go) begin
        check("ld_re", mem_read_enable, 1'b1);
        check("ld_we", mem_write_enable, 1'b0);
        check("ld_addr", mem_address, core_address);
        check("ld_be", mem_byte_enable, core_byte_enable);
        check("ld_rdata", core_read_data, mem_read_data);
      end else if (q.size() > 0) begin
        check("wr_we", mem_write_enable, 1'b1);
        check("wr_re", mem_read_enable, 1'b0);
        check("wr_addr", mem_address, {q[0].addr[31:2], 2'b00});
        check("wr_data", mem_write_data, q[0].data);
        check("wr_be", mem_byte_enable, q[0].be);
        check("wr_rdata", core_read_data, 32'h0);
        if (mem_ready) begin
          void'(q.pop_front());
          n_writes++;
        end
      end else begin
        check("idle_we", mem_write_enable, 1'b0);
        check("idle_re", mem_read_enable, 1'b0);
        check("idle_addr", mem_address, 32'h0);
        check("idle_data", mem_write_data, 32'h0);
        check("idle_be", mem_byte_enable, 4'h0);
        check("idle_rdata", core_read_data, 32'h0);
      end
      if (core_write_enable && !ld && !full) begin
        e.addr = core_address;
        e.data = core_write_data;
        e.be   = core_byte_enable;
        q.push_back(e);
      end
    end
  end

  task automatic idle_inputs();
    core_read_enable  = 1'b0;
    core_write_enable = 1'b0;
    core_address      = '0;
    core_write_data   = '0;
    core_byte_enable  = '0;
  endtask

  // Issue one request at posedge+1 and hold it while stalled; returns stall count and load data.
  task automatic req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input bit rnd, output int stalls,
                     output logic [31:0] rdata);
    core_read_enable  = rd;
    core_write_enable = wr;
    core_address      = a;
    core_write_data   = d;
    core_byte_enable  = be;
    if (rnd) mem_ready = 1'($urandom_range(0, 1));
    stalls = 0;
    #2;
    while (core_stall && stalls < 50) begin
      @(posedge clock); #1;
      if (rnd) mem_ready = 1'($urandom_range(0, 1));
      #2;
      stalls++;
    end
    if (core_stall) check("req_timeout", core_stall, 1'b0);
    rdata = core_read_data;
    @(posedge clock); #1;
    idle_inputs();
  endtask

  task automatic drain();
    mem_ready = 1'b1;
    for (int k = 0; k < 50 && !buffer_empty; k++) begin
      @(posedge clock); #1;
    end
    check("drain_empty", buffer_empty, 1'b1);
  endtask

  initial begin
    int          st;
    int          n0;
    logic [31:0] rd;
    reset         = 1'b1;
    mem_ready     = 1'b0;
    mem_read_data = '0;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    check("init_empty", buffer_empty, 1'b1);
    check("init_stall", core_stall, 1'b0);
    reset = 1'b0;

    // Store then drain
    mem_ready = 1'b1;
    req(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, st, rd);
    check("st_stall", st, 0);
    #2;
    check("st_we", mem_write_enable, 1'b1);
    check("st_addr", mem_address, 32'h100);
    check("st_data", mem_write_data, 32'hDEADBEEF);
    @(posedge clock); #1;
    check("st_empty", buffer_empty, 1'b1);

    // Fill and full
    mem_ready = 1'b0;
    n0 = n_writes;
    for (int i = 0; i < 4; i++) begin
      req(1'b0, 1'b1, 32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 1'b0, st, rd);
      check("fill_stall", st, 0);
    end
    core_write_enable = 1'b1;
    core_address      = 32'h210;
    core_write_data   = 32'hA000_0004;
    core_byte_enable  = 4'h3;
    #2;
    check("full_stall", core_stall, 1'b1);
    @(posedge clock); #1;
    mem_ready = 1'b1;
    #2;
    check("full_pop_stall", core_stall, 1'b1);
    check("full_pop_addr", mem_address, 32'h200);
    @(posedge clock); #1;
    mem_ready = 1'b0;
    #2;
    check("full_accept", core_stall, 1'b0);
    @(posedge clock); #1;
    idle_inputs();
    drain();
    check("fill_count", n_writes - n0, 5);

    // Load hazard
    mem_ready = 1'b0;
    req(1'b0, 1'b1, 32'h300, 32'h1111_3000, 4'hF, 1'b0, st, rd);
    req(1'b0, 1'b1, 32'h304, 32'h1111_3004, 4'h1, 1'b0, st, rd);
    mem_ready     = 1'b1;
    mem_read_data = 32'hCAFE_0001;
    req(1'b1, 1'b0, 32'h305, 32'h0, 4'h2, 1'b0, st, rd);
    check("hz_stalls", st, 2);
    check("hz_rdata", rd, 32'hCAFE_0001);
    check("hz_empty", buffer_empty, 1'b1);

    // Load priority over retirement
    mem_ready = 1'b0;
    req(1'b0, 1'b1, 32'h500, 32'h2222_5000, 4'hF, 1'b0, st, rd);
    req(1'b0, 1'b1, 32'h504, 32'h2222_5004, 4'hC, 1'b0, st, rd);
    mem_ready     = 1'b1;
    mem_read_data = 32'h1234_5678;
    n0 = n_writes;
    req(1'b1, 1'b0, 32'h400, 32'h0, 4'hF, 1'b0, st, rd);
    check("pri_stalls", st, 0);
    check("pri_rdata", rd, 32'h1234_5678);
    check("pri_nowrite", n_writes - n0, 0);
    #2;
    check("pri_head", mem_address, 32'h500);
    drain();
    check("pri_count", n_writes - n0, 2);

    // Pointer wrap with random memory ready
    n0 = n_writes;
    for (int i = 0; i < 10; i++) begin
      req(1'b0, 1'b1, 32'h800 + 32'(4 * i), $urandom, 4'(1 + $urandom_range(0, 14)), 1'b1, st, rd);
    end
    drain();
    check("wrap_count", n_writes - n0, 10);

    // Load with random ready after the queue is empty
    mem_read_data = 32'h0BAD_F00D;
    req(1'b1, 1'b0, 32'hA02, 32'h0, 4'h4, 1'b1, st, rd);
    check("ld_rnd_rdata", rd, 32'h0BAD_F00D);

    // Reset mid-operation with a held write
    mem_ready = 1'b0;
    req(1'b0, 1'b1, 32'h900, 32'h3333_0900, 4'hF, 1'b0, st, rd);
    req(1'b0, 1'b1, 32'h904, 32'h3333_0904, 4'hF, 1'b0, st, rd);
    req(1'b0, 1'b1, 32'h908, 32'h3333_0908, 4'hF, 1'b0, st, rd);
    #2;
    check("mid_held_we", mem_write_enable, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_we", mem_write_enable, 1'b0);
    check("mid_rst_empty", buffer_empty, 1'b1);
    check("mid_rst_addr", mem_address, 32'h0);
    @(posedge clock); #1;
    reset     = 1'b0;
    mem_ready = 1'b1;
    n0 = n_writes;
    repeat (4) @(posedge clock);
    #1;
    check("mid_nowrite", n_writes - n0, 0);
    check("mid_we", mem_write_enable, 1'b0);
    check("mid_empty", buffer_empty, 1'b1);

    repeat (2) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_store_buffer.md
# data_store_buffer

Posted-write buffer between the core's data memory interface bus (`bus_*` outputs of the core) and a data memory/peripheral bus that may take multiple cycles per transfer. Core stores are queued in a small FIFO and retired to memory in the background, so stores do not stall the pipeline unless the buffer is full. Loads pass straight through with priority over retirement. Loads that hit a queued word stall until that word has been written out. The block drives a `core_stall` output that the pipeline uses to freeze all stages.

## Interface
- `DEPTH`, 4: number of buffer entries; power of two, ≥ 2.
- `clock`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears the buffer.
- `core_address`  in  32  byte address from the core.
- `core_write_data`  in  32  store data, already lane-aligned.
- `core_byte_enable`  in  4  byte lanes for the store or load.
- `core_read_enable`  in  1  load request.
- `core_write_enable`  in  1  store request.
- `core_read_data`  out  32  load data returned to the core.
- `core_stall`  out  1  core must hold its request and pipeline stable this cycle.
- `mem_address`  out  32  memory transfer address.
- `mem_write_data`  out  32  memory store data.
- `mem_byte_enable`  out  4  memory byte lanes.
- `mem_read_enable`  out  1  memory load request.
- `mem_write_enable`  out  1  memory store request.
- `mem_read_data`  in  32  memory load data; valid when `mem_ready` is 1.
- `mem_ready`  in  1  memory completes the presented transfer this cycle.
- `buffer_empty`  out  1  no queued stores; used by the future fence logic.

## Operation
- **Storage.** The FIFO holds `DEPTH` entries of {word address `[31:2]`, data, byte_enable}. It uses registered head and tail pointers, each `log2(DEPTH)` bits wide and wrapping modulo `DEPTH`, plus a count of `log2(DEPTH)+1` bits.
- **Store accept.** A store is accepted when `core_write_enable` is 1 and count < `DEPTH`. The entry is written at the tail on the rising edge and the tail pointer increments. When count = `DEPTH`, `core_stall` = 1.
- **Full and pop in the same cycle.** Fullness is judged on the registered count. If the buffer is full and an entry pops in the same cycle, the stalled store is still refused that cycle and is accepted on the next cycle.
- **Load hazard.** A load hazard exists when `core_read_enable` = 1 and the load's word address `[31:2]` equals the word address of any valid entry. Byte enables are ignored for this comparison.
- **Load, no hazard.**
  - Drive `mem_read_enable` = 1, `mem_address` = `core_address` and `mem_byte_enable` = `core_byte_enable`.
  - `core_read_data` = `mem_read_data`.
  - `core_stall` = not `mem_ready`.
  - No store retirement happens in that cycle.
- **Load, hazard.** `core_stall` = 1, `mem_read_enable` = 0, and the buffer retires entries. The load proceeds on the first cycle after the last matching entry has popped.
- **Retirement.** When no load owns the port and count > 0:
  - Present the head entry: `mem_write_enable` = 1, `mem_address` = {word address, 2'b00}, plus the entry's data and byte_enable.
  - On a cycle with `mem_ready` = 1, pop the head (head pointer increments).
- **Push and pop together.** A push and a pop in the same cycle leave the count unchanged.
- **Port exclusivity.** `mem_read_enable` and `mem_write_enable` are never both 1.
- **Both core enables set.** `core_read_enable` and `core_write_enable` both set is illegal. The bench asserts it never happens, and the RTL treats it as a load.
- **Idle outputs.** When idle, `mem_address`, `mem_write_data`, `mem_byte_enable` and `core_read_data` are 0.
- **Status.** `buffer_empty` = (count == 0).

## Timing
- **Reset.** Reset asserted, at any time, clears count and both pointers immediately. After reset with idle core inputs, all outputs are 0 except `buffer_empty` = 1. A store that was being presented to memory is abandoned and its entry discarded.
- **Output logic.** All outputs are combinational from the registered FIFO state and the current inputs. There is no added register stage on the memory port.
- **Store latency.** A store is accepted at edge N and is first presented to memory in cycle N+1.
- **Load latency.** A load with no hazard and `mem_ready` = 1 in the same cycle completes with zero stall cycles.
- **Memory handshake.** While `mem_ready` = 0, the block holds the presented request and all its fields stable. A load that displaced retirement may not be abandoned, because the core holds it during the stall.
- **Core handshake.** While `core_stall` = 1, the core holds its inputs stable. A request completes in the first cycle with `core_stall` = 0.

## Test plan
- **Store then drain.** Reset, then store 0xDEADBEEF to 0x100 (be=4'hF) with `mem_ready` tied 1 → no stall. In the next cycle `mem_write_enable` = 1, `mem_address` = 0x100, data 0xDEADBEEF. `buffer_empty` returns to 1 one cycle later.
- **Fill and full.** With `mem_ready` = 0, issue 5 back-to-back stores to 0x200..0x210 (DEPTH=4) → the first 4 are accepted with no stall, and `core_stall` = 1 on the 5th. Raise `mem_ready` for one cycle → 0x200 pops, and the 5th store is accepted on the following edge.
- **Load hazard.** With stores to 0x300 and 0x304 queued and `mem_ready` = 1, load from 0x305 → `core_stall` stays 1 until 0x304 has retired. The load is then issued, and `core_read_data` = `mem_read_data`.
- **Load priority.** With 2 stores queued, load from 0x400 (no match) with `mem_ready` = 1 → `mem_read_enable` = 1, `mem_write_enable` = 0, zero stall cycles. The queue depth is still 2 afterwards.
- **Pointer wrap.** Perform 10 stores with random `mem_ready` → memory receives all 10 in order with the correct data and byte enables, and count never exceeds 4.
- **Reset mid-operation.** Assert `reset` mid-operation with 3 entries queued and a write held (`mem_ready` = 0) → outputs go idle immediately, `buffer_empty` = 1, and no further writes are issued after `reset` is released.
